// File: rtl/mult_accum_seq.sv
// rtl/mult_accum_seq.sv - operand sequencer and signed dot-product accumulator for the shift-add multiplier
// Optional saturating accumulation: define MACC_SAT_EN.
module mult_accum_seq #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_A,
    input  logic [7:0]       in_B,
    input  logic             in_last,
    output logic             mult_start,
    output logic [7:0]       mult_A,
    output logic [7:0]       mult_B,
    input  logic             mult_done,
    input  logic [15:0]      mult_out,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ack,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_OUT
    } state_t;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic              last_q, last_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  sum_raw;
    logic [ACC_W-1:0]  acc_next;
    logic              add_ovf;

    // Signed overflow: addends agree in sign but the result does not.
    always_comb begin
        addend   = ACC_W'($signed(mult_out));
        sum_raw  = acc_q + addend;
        add_ovf  = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef MACC_SAT_EN
        if (add_ovf) begin
            acc_next = addend[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            acc_next = sum_raw;
        end
`else
        acc_next = sum_raw;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_A;
                    b_d     = in_B;
                    last_d  = in_last;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mult_done) begin
                    acc_d   = acc_next;
                    count_d = count_q + CNT_W'(1);
                    ovf_d   = ovf_q | add_ovf;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The multiplier must see start low before the next operand pair.
                if (!mult_done) begin
                    if (last_q) begin
                        sum_d   = acc_q;
                        last_d  = 1'b0;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (sum_ack) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode the state register so reset drops start at once.
    assign in_ready   = (state_q == S_IDLE);
    assign mult_start = (state_q == S_ISSUE);
    assign sum_valid  = (state_q == S_OUT);
    assign mult_A     = a_q;
    assign mult_B     = b_q;
    assign sum        = sum_q;
    assign count      = count_q;
    assign ovf        = ovf_q;

endmodule
